exp_adder_pipe: RTL and testbench

Pipelined, parametrised multi-precision exponent adder for the posit FMA datapath. Adds two operand pairs (A+B -> E, C+D -> F) in 4-lane, 2-lane or 1-lane packing, selected per transaction. Sums are signed or unsigned, and each sum is one bit wider per narrow lane. Stage 2 compares E and F per lane and emits the larger value plus a select flag for the downstream alignment shifter. Elastic valid/ready interface at both ends.

---
 rtl/exp_adder_pipe.sv | 198 +++++++++++++++++++
 tb/tb_exp_adder_pipe.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/exp_adder_pipe.sv
// exp_adder_pipe: 2-stage multi-precision exponent adder with per-lane max.
// Ports: clk, rst_n; in_valid/in_ready, mode, exp_A..exp_D (IW) in;
//        out_valid/out_ready, exp_E/exp_F/exp_max (OW), f_gt_e, out_mode,
//        mode_err out. Stage 1 adds A+B and C+D per lane; stage 2 compares.
module exp_adder_pipe #(
   parameter int LANE_W = 4,
   parameter bit SIGNED = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [1:0]              mode,
   input  logic [4*LANE_W-1:0]     exp_A,
   input  logic [4*LANE_W-1:0]     exp_B,
   input  logic [4*LANE_W-1:0]     exp_C,
   input  logic [4*LANE_W-1:0]     exp_D,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [4*(LANE_W+1)-1:0] exp_E,
   output logic [4*(LANE_W+1)-1:0] exp_F,
   output logic [4*(LANE_W+1)-1:0] exp_max,
   output logic [3:0]              f_gt_e,
   output logic [1:0]              out_mode,
   output logic                    mode_err
);

   localparam int IW = 4*LANE_W;
   localparam int NW = LANE_W+1;
   localparam int OW = 4*NW;
   localparam int HW = 2*LANE_W;
   localparam int MW = 2*NW;

   function automatic logic [NW-1:0] add_n(
      input logic [LANE_W-1:0] a,
      input logic [LANE_W-1:0] b
   );
      logic xa, xb;
      xa = SIGNED & a[LANE_W-1];
      xb = SIGNED & b[LANE_W-1];
      return {xa, a} + {xb, b};
   endfunction

   // Extending the operands by two bits equals extending the sum by one.
   function automatic logic [MW-1:0] add_m(
      input logic [HW-1:0] a,
      input logic [HW-1:0] b
   );
      logic xa, xb;
      xa = SIGNED & a[HW-1];
      xb = SIGNED & b[HW-1];
      return {{2{xa}}, a} + {{2{xb}}, b};
   endfunction

   function automatic logic [OW-1:0] add_w(
      input logic [IW-1:0] a,
      input logic [IW-1:0] b
   );
      logic xa, xb;
      xa = SIGNED & a[IW-1];
      xb = SIGNED & b[IW-1];
      return {{4{xa}}, a} + {{4{xb}}, b};
   endfunction

   function automatic logic [OW-1:0] pack_sum(
      input logic [1:0]    m,
      input logic [IW-1:0] a,
      input logic [IW-1:0] b
   );
      logic [OW-1:0] s;
      s = '0;
      unique case (1'b1)
         m == 2'b00:
            for (int i = 0; i < 4; i++)
               s[i*NW +: NW] = add_n(a[i*LANE_W +: LANE_W],
                                     b[i*LANE_W +: LANE_W]);
         m == 2'b01:
            for (int j = 0; j < 2; j++)
               s[j*MW +: MW] = add_m(a[j*HW +: HW],
                                     b[j*HW +: HW]);
         m == 2'b10:
            s = add_w(a, b);
         default:
            s = '0;
      endcase
      return s;
   endfunction

   function automatic logic gt_n(
      input logic [NW-1:0] f,
      input logic [NW-1:0] e
   );
      if (SIGNED) return $signed(f) > $signed(e);
      return f > e;
   endfunction

   function automatic logic gt_m(
      input logic [MW-1:0] f,
      input logic [MW-1:0] e
   );
      if (SIGNED) return $signed(f) > $signed(e);
      return f > e;
   endfunction

   function automatic logic gt_w(
      input logic [OW-1:0] f,
      input logic [OW-1:0] e
   );
      if (SIGNED) return $signed(f) > $signed(e);
      return f > e;
   endfunction

   logic          s1_valid;
   logic [OW-1:0] s1_e;
   logic [OW-1:0] s1_f;
   logic [1:0]    s1_mode;
   logic          s1_err;

   logic          s1_adv;
   logic          in_fire;

   logic [OW-1:0] cmp_max;
   logic [3:0]    cmp_flag;

   // Stage 2 can take new data when empty or when its result leaves now.
   assign s1_adv   = !out_valid || out_ready;
   assign in_ready = !s1_valid || s1_adv;
   assign in_fire  = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_e     <= '0;
         s1_f     <= '0;
         s1_mode  <= 2'b00;
         s1_err   <= 1'b0;
      end else if (in_fire) begin
         s1_valid <= 1'b1;
         s1_e     <= pack_sum(mode, exp_A, exp_B);
         s1_f     <= pack_sum(mode, exp_C, exp_D);
         s1_mode  <= mode;
         s1_err   <= (mode == 2'b11);
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   always_comb begin
      cmp_max  = '0;
      cmp_flag = '0;
      unique case (1'b1)
         s1_mode == 2'b00:
            for (int i = 0; i < 4; i++) begin
               cmp_flag[i] = gt_n(s1_f[i*NW +: NW], s1_e[i*NW +: NW]);
               cmp_max[i*NW +: NW] = cmp_flag[i] ? s1_f[i*NW +: NW]
                                                 : s1_e[i*NW +: NW];
            end
         s1_mode == 2'b01:
            for (int j = 0; j < 2; j++) begin
               cmp_flag[2*j]   = gt_m(s1_f[j*MW +: MW], s1_e[j*MW +: MW]);
               cmp_flag[2*j+1] = cmp_flag[2*j];
               cmp_max[j*MW +: MW] = cmp_flag[2*j] ? s1_f[j*MW +: MW]
                                                   : s1_e[j*MW +: MW];
            end
         s1_mode == 2'b10: begin
            cmp_flag = {4{gt_w(s1_f, s1_e)}};
            cmp_max  = cmp_flag[0] ? s1_f : s1_e;
         end
         default: begin
            cmp_max  = '0;
            cmp_flag = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         exp_E     <= '0;
         exp_F     <= '0;
         exp_max   <= '0;
         f_gt_e    <= '0;
         out_mode  <= 2'b00;
         mode_err  <= 1'b0;
      end else if (s1_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            exp_E    <= s1_e;
            exp_F    <= s1_f;
            exp_max  <= cmp_max;
            f_gt_e   <= cmp_flag;
            out_mode <= s1_mode;
            mode_err <= s1_err;
         end
      end
   end

endmodule

// File: tb/tb_exp_adder_pipe.sv
// tb_exp_adder_pipe: directed vectors for exp_adder_pipe (LANE_W=4,
// SIGNED=1): latency, modes, ties, backpressure, mode 11, async reset.
module tb_exp_adder_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  mode;
   logic [15:0] exp_A, exp_B, exp_C, exp_D;
   logic        out_valid;
   logic        out_ready;
   logic [19:0] exp_E, exp_F, exp_max;
   logic [3:0]  f_gt_e;
   logic [1:0]  out_mode;
   logic        mode_err;

   int checks = 0;
   int errors = 0;

   exp_adder_pipe #(.LANE_W(4), .SIGNED(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
      .exp_A(exp_A), .exp_B(exp_B), .exp_C(exp_C), .exp_D(exp_D),
      .out_valid(out_valid), .out_ready(out_ready),
      .exp_E(exp_E), .exp_F(exp_F), .exp_max(exp_max),
      .f_gt_e(f_gt_e), .out_mode(out_mode), .mode_err(mode_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hand-computed vectors: mode, A, B, C, D -> E, F, max, flags.
   logic [1:0]  v_md[6];
   logic [15:0] v_a[6], v_b[6], v_c[6], v_d[6];
   logic [19:0] v_e[6], v_f[6], v_m[6];
   logic [3:0]  v_g[6];

   typedef struct {
      logic [19:0] e, f, m;
      logic [3:0]  g;
      logic [1:0]  md;
      logic        err;
   } res_t;
   res_t q[$];

   always begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready)
         q.push_back('{exp_E, exp_F, exp_max, f_gt_e, out_mode, mode_err});
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic put(input int v);
      in_valid = 1'b1;
      mode     = v_md[v];
      exp_A    = v_a[v];
      exp_B    = v_b[v];
      exp_C    = v_c[v];
      exp_D    = v_d[v];
   endtask

   task automatic send(input int v);
      put(v);
      #1;
      for (int k = 0; k < 20 && !in_ready; k++) begin
         @(negedge clk);
         #1;
      end
      check("accept", 32'(in_ready), 32'd1);
      @(negedge clk);
   endtask

   task automatic chk_res(input string tag, input res_t r, input int v);
      check({tag, "_E"}, 32'(r.e), 32'(v_e[v]));
      check({tag, "_F"}, 32'(r.f), 32'(v_f[v]));
      check({tag, "_max"}, 32'(r.m), 32'(v_m[v]));
      check({tag, "_flag"}, 32'(r.g), 32'(v_g[v]));
      check({tag, "_mode"}, 32'(r.md), 32'(v_md[v]));
      check({tag, "_err"}, 32'(r.err), 32'(v_md[v] == 2'b11));
   endtask

   task automatic single(input int v);
      res_t r;
      put(v);
      #1;
      check("sg_rdy", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("sg_lat1", 32'(out_valid), 32'd0);
      @(negedge clk);
      #1;
      check("sg_lat2", 32'(out_valid), 32'd1);
      r = '{exp_E, exp_F, exp_max, f_gt_e, out_mode, mode_err};
      chk_res($sformatf("sg%0d", v), r, v);
      @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      check({tag, "_ov"}, 32'(out_valid), 32'd0);
      check({tag, "_E"}, 32'(exp_E), 32'd0);
      check({tag, "_F"}, 32'(exp_F), 32'd0);
      check({tag, "_max"}, 32'(exp_max), 32'd0);
      check({tag, "_flag"}, 32'(f_gt_e), 32'd0);
      check({tag, "_mode"}, 32'(out_mode), 32'd0);
      check({tag, "_err"}, 32'(mode_err), 32'd0);
   endtask

   initial begin
      v_md = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd2, 2'd3};
      v_a  = '{16'h0087, 16'h007F, 16'h8000, 16'h1234, 16'h0001, 16'h1234};
      v_b  = '{16'h0087, 16'h0001, 16'hFFFF, 16'h4321, 16'h0000, 16'h4321};
      v_c  = '{16'h0011, 16'h0300, 16'h0005, 16'h0F0F, 16'h0000, 16'h0F0F};
      v_d  = '{16'h0011, 16'h0200, 16'h0000, 16'h0F0F, 16'h0001, 16'h0F0F};
      v_e  = '{20'h0020E, 20'h00080, 20'hF7FFF, 20'h294A5, 20'h00001, 20'h0};
      v_f  = '{20'h00042, 20'h01400, 20'h00005, 20'h0781E, 20'h00001, 20'h0};
      v_m  = '{20'h0004E, 20'h01480, 20'h00005, 20'h294A5, 20'h00001, 20'h0};
      v_g  = '{4'h2, 4'hC, 4'hF, 4'h0, 4'h0, 4'h0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      mode      = 2'b00;
      exp_A     = '0;
      exp_B     = '0;
      exp_C     = '0;
      exp_D     = '0;

      repeat (2) @(negedge clk);
      #1;
      chk_zero("rst");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel_rdy", 32'(in_ready), 32'd1);
      @(negedge clk);

      for (int v = 0; v < 6; v++)
         single(v);

      // Backpressure: two accepted, outputs frozen, then in-order drain.
      q.delete();
      out_ready = 1'b0;
      put(0);
      #1;
      check("bp_rdy0", 32'(in_ready), 32'd1);
      @(negedge clk);
      put(1);
      #1;
      check("bp_rdy1", 32'(in_ready), 32'd1);
      @(negedge clk);
      put(2);
      #1;
      check("bp_rdy2", 32'(in_ready), 32'd0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         #1;
         check("bp_hold_rdy", 32'(in_ready), 32'd0);
         check("bp_hold_ov", 32'(out_valid), 32'd1);
         check("bp_hold_E", 32'(exp_E), 32'(v_e[0]));
         check("bp_hold_max", 32'(exp_max), 32'(v_m[0]));
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      check("bp_open", 32'(in_ready), 32'd1);
      @(negedge clk);
      send(3);
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      #3;
      check("bp_count", 32'(q.size()), 32'd4);
      for (int i = 0; i < 4 && i < q.size(); i++)
         chk_res($sformatf("bp%0d", i), q[i], i);

      // Mode 11 sandwiched between two legal transactions.
      @(negedge clk);
      q.delete();
      send(0);
      send(5);
      send(3);
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      #3;
      check("b2b_count", 32'(q.size()), 32'd3);
      if (q.size() == 3) begin
         chk_res("b2b0", q[0], 0);
         chk_res("b2b1", q[1], 5);
         chk_res("b2b2", q[2], 3);
      end

      // Asynchronous reset with both stages occupied.
      @(negedge clk);
      out_ready = 1'b0;
      send(0);
      send(1);
      in_valid = 1'b0;
      #1;
      check("pre_rst_ov", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("mid_rst");
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      check("post_rst_rdy", 32'(in_ready), 32'd1);
      check("post_rst_ov", 32'(out_valid), 32'd0);
      @(negedge clk);
      single(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
